// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 sensor-side emulator: accepts a trigger pulse and answers with an
// echo pulse whose width encodes a programmed distance in mm.
// Optional feature macro: HCSR04_ECHO_JITTER_EN adds a 0..15 cycle LFSR
// jitter to every echo width.
module hcsr04_echo_emulator #(
  parameter int unsigned CYCLES_PER_MM      = 294,
  parameter int unsigned MIN_TRIG_CYCLES    = 500,
  parameter int unsigned BURST_DELAY_CYCLES = 10000,
  parameter int unsigned MIN_DIST_MM        = 20,
  parameter int unsigned MAX_DIST_MM        = 4000,
  parameter int unsigned NO_ECHO_CYCLES     = 1900000,
  parameter int unsigned HOLDOFF_CYCLES     = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic [15:0] distance_mm,
  output logic        echo,
  output logic        busy,
  output logic        short_trig
);

  localparam int unsigned CNT_W = 22;

  localparam logic [CNT_W-1:0] MIN_TRIG   = CNT_W'(MIN_TRIG_CYCLES);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] NO_ECHO_W  = CNT_W'(NO_ECHO_CYCLES);
  localparam logic [CNT_W-1:0] MIN_DIST_W = CNT_W'(MIN_DIST_MM * CYCLES_PER_MM);
  localparam logic [CNT_W-1:0] CPM        = CNT_W'(CYCLES_PER_MM);
  localparam logic [15:0]      MIN_DIST   = 16'(MIN_DIST_MM);
  localparam logic [15:0]      MAX_DIST   = 16'(MAX_DIST_MM);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG_HI = 3'd1,
    DELAY   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t           state;
  logic             trig_meta;
  logic             trig_s;
  logic             need_low;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] base_w;
  logic [CNT_W-1:0] width_next;

`ifdef HCSR04_ECHO_JITTER_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  // Fibonacci LFSR step, taps 16,14,13,11
  always_comb begin
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`endif

  // Two-flop synchronizer for the asynchronous trigger
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_meta <= 1'b0;
      trig_s    <= 1'b0;
    end else begin
      trig_meta <= trigger;
      trig_s    <= trig_meta;
    end
  end

  // Echo width from the current distance: clamp low, no-target above range
  always_comb begin
    if (distance_mm < MIN_DIST) begin
      base_w = MIN_DIST_W;
    end else if (distance_mm > MAX_DIST) begin
      base_w = NO_ECHO_W;
    end else begin
      base_w = CNT_W'(distance_mm) * CPM;
    end
`ifdef HCSR04_ECHO_JITTER_EN
    width_next = base_w + CNT_W'(lfsr_next[3:0]);
`else
    width_next = base_w;
`endif
  end

  // Protocol FSM with registered echo/busy/short_trig
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      width_q    <= '0;
      need_low   <= 1'b0;
      echo       <= 1'b0;
      busy       <= 1'b0;
      short_trig <= 1'b0;
`ifdef HCSR04_ECHO_JITTER_EN
      lfsr       <= 16'hACE1;
`endif
    end else begin
      short_trig <= 1'b0;
      case (state)
        IDLE: begin
          if (need_low) begin
            if (!trig_s) need_low <= 1'b0;
          end else if (trig_s) begin
            cnt   <= CNT_W'(1);
            state <= TRIG_HI;
          end
        end
        TRIG_HI: begin
          if (trig_s) begin
            if (cnt < MIN_TRIG) cnt <= cnt + CNT_W'(1);
          end else if (cnt >= MIN_TRIG) begin
            width_q <= width_next;
            busy    <= 1'b1;
            cnt     <= BURST_LAST;
            state   <= DELAY;
`ifdef HCSR04_ECHO_JITTER_EN
            lfsr    <= lfsr_next;
`endif
          end else begin
            short_trig <= 1'b1;
            cnt        <= '0;
            state      <= IDLE;
          end
        end
        DELAY: begin
          if (cnt == '0) begin
            echo  <= 1'b1;
            cnt   <= width_q - CNT_W'(1);
            state <= ECHO;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ECHO: begin
          if (cnt == '0) begin
            echo  <= 1'b0;
            cnt   <= HOLD_LAST;
            state <= HOLDOFF;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLDOFF: begin
          if (cnt == '0) begin
            busy     <= 1'b0;
            need_low <= trig_s;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// Scoreboard bench for hcsr04_echo_emulator, run with scaled-down timing
// parameters so full protocol sequences fit in a short simulation.
module tb_hcsr04_echo_emulator;

  localparam int CPM   = 2;
  localparam int MINT  = 20;
  localparam int BURST = 40;
  localparam int MIND  = 20;
  localparam int MAXD  = 4000;
  localparam int NOECH = 9000;
  localparam int HOLD  = 200;
`ifdef HCSR04_ECHO_JITTER_EN
  localparam int JIT = 15;
`else
  localparam int JIT = 0;
`endif

  typedef struct {
    int rise;
    int wmin;
    int wmax;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0;
  logic [15:0] distance_mm = 16'd0;
  logic        echo;
  logic        busy;
  logic        short_trig;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   shorts = 0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  logic prev_echo = 1'b0;
  logic prev_busy = 1'b0;
  exp_t exp_q[$];
  int   obs_q[$];

  hcsr04_echo_emulator #(
    .CYCLES_PER_MM(CPM),
    .MIN_TRIG_CYCLES(MINT),
    .BURST_DELAY_CYCLES(BURST),
    .MIN_DIST_MM(MIND),
    .MAX_DIST_MM(MAXD),
    .NO_ECHO_CYCLES(NOECH),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trigger(trigger),
    .distance_mm(distance_mm),
    .echo(echo),
    .busy(busy),
    .short_trig(short_trig)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model_width(input int d);
    if (d < MIND) return MIND * CPM;
    if (d > MAXD) return NOECH;
    return d * CPM;
  endfunction

  // Output monitor: checks echo timing against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_echo = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (echo && !prev_echo) begin
        rise_cyc = cyc;
        pulses++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_echo: echo rose at cycle %0d, required no echo", cyc);
        end else if (cyc !== exp_q[0].rise) begin
          errors++;
          $display("FAIL echo_rise: rose at cycle %0d, required %0d", cyc, exp_q[0].rise);
        end
      end
      if (!echo && prev_echo) begin
        fall_cyc = cyc;
        obs_q.push_back(cyc - rise_cyc);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          if ((cyc - rise_cyc) < e.wmin || (cyc - rise_cyc) > e.wmax) begin
            errors++;
            $display("FAIL echo_width: width %0d, required %0d..%0d", cyc - rise_cyc, e.wmin, e.wmax);
          end
        end
      end
      if (!busy && prev_busy) begin
        checks++;
        if ((cyc - fall_cyc) !== HOLD) begin
          errors++;
          $display("FAIL busy_holdoff: busy fell %0d cycles after echo, required %0d", cyc - fall_cyc, HOLD);
        end
      end
      if (short_trig) shorts++;
      prev_echo = echo;
      prev_busy = busy;
    end
  end

  task automatic pulse_trig(input int n, input int d, input bit accept);
    @(posedge clk); #1;
    distance_mm = 16'(d);
    trigger = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    trigger = 1'b0;
    if (accept) begin
      exp_t e;
      e.rise = cyc + 3 + BURST;
      e.wmin = model_width(d);
      e.wmax = model_width(d) + JIT;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    ok = 1'b0;
    repeat (5) @(posedge clk);
    for (n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (!busy && !echo && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_echo(input logic level, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (echo === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    trigger = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (echo !== 1'b0) begin errors++; $display("FAIL reset_echo: echo=%b, required 0", echo); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b, required 0", busy); end
    checks++;
    if (short_trig !== 1'b0) begin errors++; $display("FAIL reset_short: short_trig=%b, required 0", short_trig); end
  endtask

  task automatic test_basic();
    bit ok;
    int p0, s0;
    p0 = pulses; s0 = shorts;
    pulse_trig(30, 100, 1'b1);
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout: ok=%b, required 1", ok); end
    checks++;
    if (pulses - p0 !== 1) begin errors++; $display("FAIL basic_pulses: %0d pulses, required 1", pulses - p0); end
    checks++;
    if (shorts - s0 !== 0) begin errors++; $display("FAIL basic_short: %0d short_trig, required 0", shorts - s0); end
  endtask

  task automatic test_min_trig();
    bit ok;
    int p0, s0;
    p0 = pulses; s0 = shorts;
    pulse_trig(MINT - 1, 100, 1'b0);
    wait_idle(ok);
    checks++;
    if (shorts - s0 !== 1) begin errors++; $display("FAIL short_reject: %0d short_trig, required 1", shorts - s0); end
    checks++;
    if (pulses - p0 !== 0) begin errors++; $display("FAIL short_no_echo: %0d pulses, required 0", pulses - p0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL short_busy: busy=%b, required 0", busy); end
    pulse_trig(MINT, 100, 1'b1);
    wait_idle(ok);
    checks++;
    if (pulses - p0 !== 1) begin errors++; $display("FAIL min_accept: %0d pulses, required 1", pulses - p0); end
    checks++;
    if (shorts - s0 !== 1) begin errors++; $display("FAIL min_accept_short: %0d short_trig, required 1", shorts - s0); end
  endtask

  task automatic test_distance_range();
    bit ok;
    int dists[4] = '{5, MAXD, MAXD + 1, 0};
    for (int i = 0; i < 4; i++) begin
      pulse_trig(30, dists[i], 1'b1);
      wait_idle(ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL range_timeout: d=%0d ok=%b, required 1", dists[i], ok); end
    end
  endtask

  task automatic test_ignore_busy();
    bit ok;
    int p0, s0;
    p0 = pulses; s0 = shorts;
    pulse_trig(30, 100, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    distance_mm = 16'd300;
    pulse_trig(10, 300, 1'b0);
    wait_echo(1'b1, ok);
    repeat (20) @(posedge clk);
    pulse_trig(30, 300, 1'b0);
    wait_echo(1'b0, ok);
    repeat (20) @(posedge clk);
    pulse_trig(30, 300, 1'b0);
    pulse_trig(5, 300, 1'b0);
    wait_idle(ok);
    checks++;
    if (pulses - p0 !== 1) begin errors++; $display("FAIL ignore_pulses: %0d pulses, required 1", pulses - p0); end
    checks++;
    if (shorts - s0 !== 0) begin errors++; $display("FAIL ignore_short: %0d short_trig, required 0", shorts - s0); end
  endtask

  task automatic test_rearm_needs_low();
    bit ok;
    int p0, s0;
    p0 = pulses; s0 = shorts;
    pulse_trig(30, 100, 1'b1);
    wait_echo(1'b1, ok);
    wait_echo(1'b0, ok);
    repeat (150) @(posedge clk);
    pulse_trig(100, 100, 1'b0);
    wait_idle(ok);
    checks++;
    if (pulses - p0 !== 1) begin errors++; $display("FAIL rearm_pulses: %0d pulses, required 1", pulses - p0); end
    checks++;
    if (shorts - s0 !== 0) begin errors++; $display("FAIL rearm_short: %0d short_trig, required 0", shorts - s0); end
  endtask

  task automatic test_held_high();
    bit ok;
    int p0, s0;
    p0 = pulses; s0 = shorts;
    @(posedge clk); #1;
    distance_mm = 16'd60;
    trigger = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || echo !== 1'b0) begin errors++; $display("FAIL held_idle: busy=%b echo=%b, required 0 0", busy, echo); end
    checks++;
    if (pulses - p0 !== 0 || shorts - s0 !== 0) begin errors++; $display("FAIL held_activity: pulses=%0d shorts=%0d, required 0 0", pulses - p0, shorts - s0); end
    trigger = 1'b0;
    begin
      exp_t e;
      e.rise = cyc + 3 + BURST;
      e.wmin = model_width(60);
      e.wmax = model_width(60) + JIT;
      exp_q.push_back(e);
    end
    wait_idle(ok);
    checks++;
    if (pulses - p0 !== 1) begin errors++; $display("FAIL held_release: %0d pulses, required 1", pulses - p0); end
  endtask

  task automatic test_reset_mid_echo();
    bit ok;
    int p0;
    pulse_trig(30, 100, 1'b1);
    wait_echo(1'b1, ok);
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (echo !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_echo: echo=%b busy=%b, required 0 0", echo, busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    p0 = pulses;
    pulse_trig(30, 50, 1'b1);
    wait_idle(ok);
    checks++;
    if (pulses - p0 !== 1) begin errors++; $display("FAIL after_reset_pulse: %0d pulses, required 1", pulses - p0); end
  endtask

`ifdef HCSR04_ECHO_JITTER_EN
  task automatic test_jitter();
    bit ok;
    int run1[8];
    int run2[8];
    for (int r = 0; r < 2; r++) begin
      do_reset();
      obs_q.delete();
      for (int i = 0; i < 8; i++) begin
        pulse_trig(30, 100, 1'b1);
        wait_idle(ok);
      end
      for (int i = 0; i < 8; i++) begin
        if (r == 0) run1[i] = (obs_q.size() > i) ? obs_q[i] : -1;
        else        run2[i] = (obs_q.size() > i) ? obs_q[i] : -2;
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (run2[i] !== run1[i]) begin errors++; $display("FAIL jitter_repeat: trigger %0d width %0d, required %0d", i, run2[i], run1[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_min_trig();
    test_distance_range();
    test_ignore_busy();
    test_rearm_needs_low();
    test_held_high();
    test_reset_mid_echo();
`ifdef HCSR04_ECHO_JITTER_EN
    test_jitter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
